// File: rtl/stall_controller.sv
// Pipeline stall controller: turns load-use and control hazards plus cache
// stalls into pipeline register load enables, a NOP insert and stall statistics.
module stall_controller #(
    parameter int CTRL_DRAIN = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 data_hazard,
    input  logic                 ctrl_hazard,
    input  logic                 ctrl_resolve,
    input  logic                 mem_stall,
    output logic                 load_pc,
    output logic                 load_if_id,
    output logic                 load_id_ex,
    output logic                 load_ex_mem,
    output logic                 load_mem_wb,
    output logic                 insert_nop,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic                 drain_timeout
);

    localparam int DW = (CTRL_DRAIN < 1) ? 1 : $clog2(CTRL_DRAIN + 1);
    localparam logic [DW-1:0]        DRAIN_LAST = DW'(CTRL_DRAIN - 1);
    localparam logic [DW-1:0]        DRAIN_ONE  = DW'(1);
    localparam logic [DW-1:0]        DRAIN_ZERO = DW'(0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_SAT    = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_CTRL_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [DW-1:0]         r_drain_cnt;
    logic [DW-1:0]         w_next_drain;
    logic                  w_set_timeout;
    logic                  w_load_pc;
    logic                  w_load_if_id;
    logic                  w_load_back;
    logic                  w_insert_nop;
    logic [CNT_WIDTH-1:0]  r_stall_cycles;
    logic                  r_drain_timeout;

    // Next-state and enable decode; reset and mem_stall freeze the whole pipe.
    always_comb begin
        w_next_state  = r_state;
        w_next_drain  = r_drain_cnt;
        w_set_timeout = 1'b0;
        w_load_pc     = 1'b1;
        w_load_if_id  = 1'b1;
        w_load_back   = 1'b1;
        w_insert_nop  = 1'b0;
        if (reset || mem_stall) begin
            w_load_pc    = 1'b0;
            w_load_if_id = 1'b0;
            w_load_back  = 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (ctrl_hazard) begin
                        w_load_pc    = 1'b0;
                        w_load_if_id = 1'b0;
                        w_insert_nop = 1'b1;
                        w_next_state = ST_CTRL_DRAIN;
                        w_next_drain = DRAIN_ZERO;
                    end else if (data_hazard) begin
                        w_load_pc    = 1'b0;
                        w_load_if_id = 1'b0;
                        w_insert_nop = 1'b1;
                        w_next_state = ST_LOAD_STALL;
                    end else begin
                        w_next_state = ST_RUN;
                    end
                end
                ST_LOAD_STALL: begin
                    w_load_pc    = 1'b0;
                    w_load_if_id = 1'b0;
                    w_insert_nop = 1'b1;
                    w_next_state = ST_RUN;
                end
                ST_CTRL_DRAIN: begin
                    w_load_if_id = 1'b0;
                    w_insert_nop = 1'b1;
                    // A resolved branch releases the PC this cycle so the target is fetched next.
                    if (ctrl_resolve) begin
                        w_load_pc    = 1'b1;
                        w_next_state = ST_RUN;
                    end else if (r_drain_cnt == DRAIN_LAST) begin
                        w_load_pc     = 1'b0;
                        w_next_state  = ST_RUN;
                        w_set_timeout = 1'b1;
                    end else begin
                        w_load_pc    = 1'b0;
                        w_next_drain = r_drain_cnt + DRAIN_ONE;
                    end
                end
                default: begin
                    w_load_pc    = 1'b0;
                    w_load_if_id = 1'b0;
                    w_insert_nop = 1'b1;
                    w_next_state = ST_RUN;
                    w_next_drain = DRAIN_ZERO;
                end
            endcase
        end
    end

    // FSM state and drain counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= DRAIN_ZERO;
        end else begin
            r_state     <= w_next_state;
            r_drain_cnt <= w_next_drain;
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= {CNT_WIDTH{1'b0}};
        end else if (!w_load_pc && (r_stall_cycles != CNT_SAT)) begin
            r_stall_cycles <= r_stall_cycles + CNT_ONE;
        end else begin
            r_stall_cycles <= r_stall_cycles;
        end
    end

    // Sticky flag for a control drain that gave up waiting for resolution.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drain_timeout <= 1'b0;
        end else if (w_set_timeout) begin
            r_drain_timeout <= 1'b1;
        end else begin
            r_drain_timeout <= r_drain_timeout;
        end
    end

    assign load_pc       = w_load_pc;
    assign load_if_id    = w_load_if_id;
    assign load_id_ex    = w_load_back;
    assign load_ex_mem   = w_load_back;
    assign load_mem_wb   = w_load_back;
    assign insert_nop    = w_insert_nop;
    assign stall_cycles  = r_stall_cycles;
    assign drain_timeout = r_drain_timeout;

endmodule

// File: tb/tb_stall_controller.sv
// Scoreboard bench for stall_controller: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares against two DUT widths.
module tb_stall_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        data_hazard = 1'b0;
    logic        ctrl_hazard = 1'b0;
    logic        ctrl_resolve = 1'b0;
    logic        mem_stall = 1'b0;

    logic        pc, ifid, idex, exmem, memwb, nop, tmo;
    logic [15:0] sc;
    logic        pc4, ifid4, idex4, exmem4, memwb4, nop4, tmo4;
    logic [3:0]  sc4;

    localparam logic [4:0] E_ALL  = 5'b11111;
    localparam logic [4:0] E_BUB  = 5'b00111;
    localparam logic [4:0] E_RES  = 5'b10111;
    localparam logic [4:0] E_ZERO = 5'b00000;

    typedef struct {
        logic [4:0]  en;
        logic        nop;
        logic [15:0] sc;
        logic [3:0]  sc4;
        logic        to;
        int          id;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_issued = 0;

    always #5 clk = ~clk;

    stall_controller u_dut (
        .clk(clk), .reset(reset), .data_hazard(data_hazard), .ctrl_hazard(ctrl_hazard),
        .ctrl_resolve(ctrl_resolve), .mem_stall(mem_stall),
        .load_pc(pc), .load_if_id(ifid), .load_id_ex(idex), .load_ex_mem(exmem),
        .load_mem_wb(memwb), .insert_nop(nop), .stall_cycles(sc), .drain_timeout(tmo)
    );

    stall_controller #(.CTRL_DRAIN(3), .CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .data_hazard(data_hazard), .ctrl_hazard(ctrl_hazard),
        .ctrl_resolve(ctrl_resolve), .mem_stall(mem_stall),
        .load_pc(pc4), .load_if_id(ifid4), .load_id_ex(idex4), .load_ex_mem(exmem4),
        .load_mem_wb(memwb4), .insert_nop(nop4), .stall_cycles(sc4), .drain_timeout(tmo4)
    );

    task automatic step(input logic r, input logic dh, input logic ch, input logic cr,
                        input logic ms, input logic [4:0] en, input logic en_nop,
                        input int exp_sc, input logic to);
        exp_t e;
        @(posedge clk);
        #1;
        reset        = r;
        data_hazard  = dh;
        ctrl_hazard  = ch;
        ctrl_resolve = cr;
        mem_stall    = ms;
        e.en  = en;
        e.nop = en_nop;
        e.sc  = 16'(exp_sc);
        e.sc4 = (exp_sc > 15) ? 4'hF : 4'(exp_sc);
        e.to  = to;
        e.id  = n_issued;
        n_issued++;
        q.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle, so one expectation per negedge.
    initial begin
        exp_t e;
        logic [4:0] act, act4;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                act  = {pc, ifid, idex, exmem, memwb};
                act4 = {pc4, ifid4, idex4, exmem4, memwb4};
                if (act !== e.en || act4 !== e.en) begin
                    n_bad++;
                    $display("FAIL enables vec %0d: got %b/%b want %b", e.id, act, act4, e.en);
                end
                if (nop !== e.nop || nop4 !== e.nop) begin
                    n_bad++;
                    $display("FAIL insert_nop vec %0d: got %b/%b want %b", e.id, nop, nop4, e.nop);
                end
                if (sc !== e.sc) begin
                    n_bad++;
                    $display("FAIL stall_cycles vec %0d: got %0d want %0d", e.id, sc, e.sc);
                end
                if (sc4 !== e.sc4) begin
                    n_bad++;
                    $display("FAIL stall_cycles_w4 vec %0d: got %0d want %0d", e.id, sc4, e.sc4);
                end
                if (tmo !== e.to || tmo4 !== e.to) begin
                    n_bad++;
                    $display("FAIL drain_timeout vec %0d: got %b/%b want %b", e.id, tmo, tmo4, e.to);
                end
            end
        end
    end

    initial begin
        int budget;
        // Load-use bubble; hazards and resolve are ignored while in LOAD_STALL.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_ZERO, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_ALL,  1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_BUB,  1'b1, 0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, E_BUB,  1'b1, 1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_ALL,  1'b0, 2, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_ALL,  1'b0, 2, 1'b0);
        // Control hazard resolved on the third cycle.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_BUB,  1'b1, 2, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_BUB,  1'b1, 3, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_RES,  1'b1, 4, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_ALL,  1'b0, 4, 1'b0);
        // Control hazard never resolved: four stalls then sticky timeout.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_BUB,  1'b1, 4, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_BUB,  1'b1, 5, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_BUB,  1'b1, 6, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_BUB,  1'b1, 7, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_ALL,  1'b0, 8, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_ALL,  1'b0, 8, 1'b1);
        // mem_stall for 5 cycles inside LOAD_STALL.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_ZERO, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_BUB,  1'b1, 0, 1'b0);
        for (int i = 1; i <= 5; i++)
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, E_ZERO, 1'b0, i, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_BUB,  1'b1, 6, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_ALL,  1'b0, 7, 1'b0);
        // mem_stall in RUN masks a hazard entirely.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, E_ZERO, 1'b0, 7, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_ALL,  1'b0, 8, 1'b0);
        // Both hazards: ctrl wins; async reset mid-drain.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, E_BUB,  1'b1, 8, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_BUB,  1'b1, 9, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_ZERO, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_ALL,  1'b0, 0, 1'b0);
        // Long mem_stall saturates the 4-bit counter.
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, E_ZERO, 1'b0, i, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_ALL,  1'b0, 20, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_ZERO, 1'b0, 0, 1'b0);

        budget = 10;
        while (q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        @(posedge clk);
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain_queue: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/stall_controller.md
STALL_CONTROLLER -- requirements
Module: stall_controller

Interface
REQ-001 Parameter: CTRL_DRAIN, default 3, maximum cycles spent in CTRL_DRAIN waiting for ctrl_resolve.
REQ-002 Parameter: CNT_WIDTH, default 16, width of the stall_cycles counter.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: data_hazard  input  1  load-use bubble request from the hazard detector.
REQ-006 Port: ctrl_hazard  input  1  br/jmp/jsr bubble request from the hazard detector.
REQ-007 Port: ctrl_resolve  input  1  control instruction resolved in MEM; PC target valid.
REQ-008 Port: mem_stall  input  1  instruction or data cache access outstanding, no response yet.
REQ-009 Port: load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  output  1 each  pipeline register load enables.
REQ-010 Port: insert_nop  output  1  ID/EX captures a NOP instead of the decoded instruction.
REQ-011 Port: stall_cycles  output  CNT_WIDTH  saturating count of cycles with load_pc low.
REQ-012 Port: drain_timeout  output  1  sticky error flag: CTRL_DRAIN exited without ctrl_resolve.

Function
REQ-013 FSM states SHALL be RUN, LOAD_STALL and CTRL_DRAIN; a drain counter of width clog2(CTRL_DRAIN+1) SHALL run in CTRL_DRAIN.
REQ-014 mem_stall=1 SHALL override all states: all load_* = 0, insert_nop = 0, and the FSM state and drain counter held.
REQ-015 Without mem_stall, RUN with no hazard: all load_* = 1, insert_nop = 0.
REQ-016 RUN with ctrl_hazard=1: this cycle load_pc=0, load_if_id=0, insert_nop=1, other loads 1; next state CTRL_DRAIN, drain counter cleared.
REQ-017 RUN with data_hazard=1 and ctrl_hazard=0: same outputs as REQ-016; next state LOAD_STALL.
REQ-018 Simultaneous data_hazard and ctrl_hazard in RUN: ctrl_hazard wins.
REQ-019 LOAD_STALL: exactly one cycle; load_pc=0, load_if_id=0, insert_nop=1, others 1; next state RUN. A load-use hazard costs exactly 2 bubbles.
REQ-020 CTRL_DRAIN, ctrl_resolve=0: load_pc=0, load_if_id=0, insert_nop=1, others 1; drain counter increments.
REQ-021 CTRL_DRAIN, ctrl_resolve=1: load_pc=1, load_if_id=0, insert_nop=1, others 1; next state RUN.
REQ-022 CTRL_DRAIN, ctrl_resolve=0 with drain counter == CTRL_DRAIN-1: outputs per REQ-020; next state RUN; drain_timeout set to 1 and held until reset.
REQ-023 data_hazard and ctrl_hazard SHALL be ignored outside RUN. ctrl_resolve SHALL be ignored outside CTRL_DRAIN.
REQ-024 stall_cycles SHALL increment by 1 on every clock edge where load_pc=0 (including mem_stall cycles) and saturate at all-ones without wrapping.
REQ-025 All outputs are combinational from state and inputs; there is no added latency between a request and its effect on the enables.

Reset
REQ-026 While reset=1, asynchronously: state=RUN, drain counter=0, stall_cycles=0, drain_timeout=0, all load_* = 0, insert_nop = 0.
REQ-027 Reset asserted mid-CTRL_DRAIN or mid-LOAD_STALL SHALL abandon the sequence; the first cycle after deassertion behaves as RUN.

Verification
REQ-028 data_hazard pulse 1 cycle in RUN -> 2 cycles with load_pc=0 and insert_nop=1, then RUN; stall_cycles=2.
REQ-029 ctrl_hazard at t0, ctrl_resolve at t0+2 (CTRL_DRAIN=3) -> load_pc low t0..t0+1, high at t0+2 with load_if_id=0; RUN at t0+3; drain_timeout=0.
REQ-030 ctrl_hazard with no ctrl_resolve (CTRL_DRAIN=3) -> 4 stall cycles, then RUN with drain_timeout=1, which stays 1 until reset.
REQ-031 mem_stall held 5 cycles during LOAD_STALL -> all enables 0 for 5 cycles, then 1 LOAD_STALL cycle, then RUN; stall_cycles=7.
REQ-032 data_hazard and ctrl_hazard together -> enters CTRL_DRAIN. Async reset mid-drain -> outputs reset values immediately; after release, RUN with stall_cycles=0.
REQ-033 CNT_WIDTH=4 with more than 15 stall cycles -> stall_cycles holds 4'hF.
